// File: rtl/pipe_reg_skid.sv
// Pipeline stage register with valid/ready handshake, a 2-entry skid buffer and flush.
// in_ready is registered, so a downstream stall never forms a combinational path upstream.
module pipe_reg_skid #(
    parameter int unsigned      WIDTH          = 32,
    parameter logic [WIDTH-1:0] RESET_VAL      = '0,
    parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] main_r;
    logic [WIDTH-1:0] main_s;
    logic [WIDTH-1:0] skid_r;
    logic [WIDTH-1:0] skid_s;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             fire_s;

    assign accept_s  = in_valid & in_ready_r;
    assign fire_s    = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_r;
    assign count     = state_r;

    // Next-state and data-path selection; flush wins over any handshake.
    always_comb begin
        state_s = state_r;
        main_s  = main_r;
        skid_s  = skid_r;
        if (flush) begin
            state_s = ST_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_s = RESET_VAL;
                skid_s = RESET_VAL;
            end else begin
                main_s = main_r;
                skid_s = skid_r;
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        main_s  = in_data;
                        state_s = ST_ONE;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && fire_s) begin
                        main_s  = in_data;
                        state_s = ST_ONE;
                    end else if (accept_s) begin
                        skid_s  = in_data;
                        state_s = ST_TWO;
                    end else if (fire_s) begin
                        state_s = ST_EMPTY;
                    end else begin
                        state_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain path exists
                    if (fire_s) begin
                        main_s  = skid_r;
                        state_s = ST_ONE;
                    end else begin
                        state_s = ST_TWO;
                    end
                end
                default: begin
                    state_s = ST_EMPTY;
                end
            endcase
        end
    end

    // State, storage and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= RESET_VAL;
            skid_r      <= RESET_VAL;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            main_r      <= main_s;
            skid_r      <= skid_s;
            in_ready_r  <= (state_s != ST_TWO);
            out_valid_r <= (state_s != ST_EMPTY);
        end
    end

    pipe_reg_skid_chk #(.WIDTH(WIDTH)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_ready  (in_ready_r),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .out_data  (main_r),
        .count     (state_r)
    );

endmodule

// Protocol checker: legal occupancy, ready/valid consistency, stall stability.
module pipe_reg_skid_chk #(
    parameter int unsigned WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input logic             flush,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_data,
    input logic [1:0]       count
);

    a_count_legal: assert property (@(posedge clk) disable iff (rst)
        count != 2'd3);

    a_ready_consistent: assert property (@(posedge clk) disable iff (rst)
        (in_ready == (count != 2'd2)) && (out_valid == (count != 2'd0)));

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid: reset, vector table, flush corners and a random
// run against a reference FIFO queue.
module tb_pipe_reg_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  count;

    logic        flush8;
    logic        in_valid8;
    logic        in_ready8;
    logic [7:0]  in_data8;
    logic        out_valid8;
    logic        out_ready8;
    logic [7:0]  out_data8;
    logic [1:0]  count8;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipe_reg_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    pipe_reg_skid #(.WIDTH(8), .RESET_VAL(8'h55), .CLEAR_ON_FLUSH(1'b0)) dut8 (
        .clk(clk), .rst(rst), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .count(count8)
    );

    typedef struct {
        logic        iv;
        logic [31:0] data;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic        eir;
        logic [1:0]  ec;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic iv, input logic [31:0] d, input logic ordy, input logic fl,
                       input logic ev, input logic [31:0] ed, input logic eir, input logic [1:0] ec);
        vecs.push_back('{iv, d, ordy, fl, ev, ed, eir, ec});
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
        flush8 = 1'b0; in_valid8 = 1'b0; in_data8 = 8'h00; out_ready8 = 1'b0;

        // Reset held two cycles with a beat offered
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_in_ready", {31'd0, in_ready}, 32'd1);
            check("rst_count", {30'd0, count}, 32'd0);
            check("rst_out_data", out_data, 32'd0);
        end
        check("rst8_out_data", {24'd0, out_data8}, 32'h55);
        rst = 1'b0;

        // Streaming 1..8 then drain
        for (int k = 1; k <= 8; k++) add(1'b1, k, 1'b1, 1'b0, 1'b1, k, 1'b1, 2'd1);
        add(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd8, 1'b1, 2'd0);
        // Back-pressure A1,A2 accepted, A3 held, then drained in order
        add(1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b1, 2'd1);
        add(1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 2'd2);
        add(1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 1'b0, 2'd2);
        add(1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA2, 1'b1, 2'd1);
        add(1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 32'hA3, 1'b1, 2'd1);
        add(1'b0, 32'd0,  1'b0, 1'b0, 1'b1, 32'hA3, 1'b1, 2'd1);
        // Fill to TWO, flush with B0 offered; B0 never emerges
        add(1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 32'hA3, 1'b0, 2'd2);
        add(1'b1, 32'hB0, 1'b0, 1'b1, 1'b0, 32'd0,  1'b1, 2'd0);
        add(1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 2'd0);
        // Flush in ONE with in_ready=1: offered beat dropped
        add(1'b1, 32'hD1, 1'b0, 1'b0, 1'b1, 32'hD1, 1'b1, 2'd1);
        add(1'b1, 32'hD2, 1'b1, 1'b1, 1'b0, 32'd0,  1'b1, 2'd0);
        add(1'b0, 32'd0,  1'b1, 1'b0, 1'b0, 32'd0,  1'b1, 2'd0);

        foreach (vecs[i]) begin
            in_valid = vecs[i].iv; in_data = vecs[i].data;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
            step();
            check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].eir});
            check($sformatf("vec%0d_count", i), {30'd0, count}, {30'd0, vecs[i].ec});
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;

        // Hold-on-flush variant, then reset restores RESET_VAL
        in_valid8 = 1'b1; in_data8 = 8'h3C;
        step();
        check("nf_load_valid", {31'd0, out_valid8}, 32'd1);
        check("nf_load_data", {24'd0, out_data8}, 32'h3C);
        in_valid8 = 1'b0; flush8 = 1'b1;
        step();
        check("nf_flush_valid", {31'd0, out_valid8}, 32'd0);
        check("nf_flush_data", {24'd0, out_data8}, 32'h3C);
        check("nf_flush_count", {30'd0, count8}, 32'd0);
        flush8 = 1'b0; rst = 1'b1;
        step();
        check("nf_rst_data", {24'd0, out_data8}, 32'h55);
        check("nf_rst_in_ready", {31'd0, in_ready8}, 32'd1);
        rst = 1'b0;

        // Random traffic against a reference queue
        for (int c = 0; c < 10000; c++) begin
            logic acc, fire;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            acc  = in_valid && (sb_q.size() < 2) && !flush;
            fire = (sb_q.size() > 0) && out_ready;
            step();
            if (flush) sb_q.delete();
            else begin
                if (fire) void'(sb_q.pop_front());
                if (acc) sb_q.push_back(in_data);
            end
            check("rnd_count", {30'd0, count}, sb_q.size());
            check("rnd_in_ready", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
            check("rnd_out_valid", {31'd0, out_valid}, {31'd0, sb_q.size() > 0});
            if (sb_q.size() > 0) check("rnd_out_data", out_data, sb_q[0]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
